// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU writeback FIFOs feeding NUM_PORTS broadcast
// ports through a rotating-priority grant that fills ports contiguously from 0.
module cdb_arbiter #(
  parameter int NUM_FU    = 6,
  parameter int NUM_PORTS = 4,
  parameter int BUF_DEPTH = 2,
  parameter int ROB_IDX   = 5,
  parameter int PRF_IDX   = 6,
  parameter int ARF_IDX   = 5,
  parameter int DATA_W    = 32,
  localparam int SRC_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 backend_flush_i,
  input  logic [NUM_FU-1:0]    fu_valid_i,
  output logic [NUM_FU-1:0]    fu_ready_o,
  input  logic [ROB_IDX-1:0]   fu_rob_id_i   [NUM_FU],
  input  logic [PRF_IDX-1:0]   fu_rd_phy_i   [NUM_FU],
  input  logic [ARF_IDX-1:0]   fu_rd_arch_i  [NUM_FU],
  input  logic [DATA_W-1:0]    fu_rd_data_i  [NUM_FU],
  input  logic                 fu_regf_we_i  [NUM_FU],
  output logic [NUM_PORTS-1:0] cdb_valid_o,
  output logic [ROB_IDX-1:0]   cdb_rob_id_o  [NUM_PORTS],
  output logic [PRF_IDX-1:0]   cdb_rd_phy_o  [NUM_PORTS],
  output logic [ARF_IDX-1:0]   cdb_rd_arch_o [NUM_PORTS],
  output logic [DATA_W-1:0]    cdb_rd_data_o [NUM_PORTS],
  output logic                 cdb_regf_we_o [NUM_PORTS],
  output logic [SRC_W-1:0]     cdb_src_o     [NUM_PORTS]
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic [ROB_IDX-1:0] robId;
    logic [PRF_IDX-1:0] rdPhy;
    logic [ARF_IDX-1:0] rdArch;
    logic [DATA_W-1:0]  rdData;
    logic               regfWe;
  } entry_t;

  entry_t            mem_q   [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0]  rdPtr_q [NUM_FU];
  logic [PTR_W-1:0]  wrPtr_q [NUM_FU];
  logic [CNT_W-1:0]  count_q [NUM_FU];
  logic [SRC_W-1:0]  rrPtr_q;
  logic [SRC_W-1:0]  rrPtr_d;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              active;

  assign active = rst_i && !backend_flush_i;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready_o[i] = active && (count_q[i] < CNT_W'(BUF_DEPTH));
    end
  end

  assign push = fu_valid_i & fu_ready_o;

  // Walk FUs starting at rrPtr_q; each non-empty FIFO takes the next free port.
  always_comb begin
    logic [SRC_W:0]  idxWide;
    logic [SRC_W-1:0] idx;
    logic [PORT_W:0] portCnt;
    entry_t          head;
    pop         = '0;
    cdb_valid_o = '0;
    rrPtr_d     = rrPtr_q;
    portCnt     = '0;
    idxWide     = '0;
    idx         = '0;
    head        = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cdb_src_o[p]     = '0;
      cdb_rob_id_o[p]  = '0;
      cdb_rd_phy_o[p]  = '0;
      cdb_rd_arch_o[p] = '0;
      cdb_rd_data_o[p] = '0;
      cdb_regf_we_o[p] = 1'b0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idxWide = {1'b0, rrPtr_q} + (SRC_W+1)'(k);
      if (idxWide >= (SRC_W+1)'(NUM_FU)) begin
        idxWide = idxWide - (SRC_W+1)'(NUM_FU);
      end
      idx = idxWide[SRC_W-1:0];
      if (active && (count_q[idx] != '0) && (portCnt < (PORT_W+1)'(NUM_PORTS))) begin
        head                              = mem_q[idx][rdPtr_q[idx]];
        pop[idx]                          = 1'b1;
        cdb_valid_o[portCnt[PORT_W-1:0]]  = 1'b1;
        cdb_src_o[portCnt[PORT_W-1:0]]     = idx;
        cdb_rob_id_o[portCnt[PORT_W-1:0]]  = head.robId;
        cdb_rd_phy_o[portCnt[PORT_W-1:0]]  = head.rdPhy;
        cdb_rd_arch_o[portCnt[PORT_W-1:0]] = head.rdArch;
        cdb_rd_data_o[portCnt[PORT_W-1:0]] = head.rdData;
        cdb_regf_we_o[portCnt[PORT_W-1:0]] = head.regfWe;
        rrPtr_d = (idx == SRC_W'(NUM_FU - 1)) ? '0 : idx + SRC_W'(1);
        portCnt = portCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || backend_flush_i) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rdPtr_q[i] <= '0;
        wrPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      rrPtr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + PTR_W'(1);
        if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + PTR_W'(1);
        count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      rrPtr_q <= rrPtr_d;
    end
  end

  // Storage needs no reset; counts alone decide which slots are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_q[i][wrPtr_q[i]] <= '{robId: fu_rob_id_i[i], rdPhy: fu_rd_phy_i[i],
                                  rdArch: fu_rd_arch_i[i], rdData: fu_rd_data_i[i],
                                  regfWe: fu_regf_we_i[i]};
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-FU expected-entry queues filled on
// accepted pushes and drained against each broadcast port.
module tb_cdb_arbiter;
  localparam int NF = 6;
  localparam int NP = 4;

  typedef struct packed {
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic [4:0]  arch;
    logic [31:0] data;
    logic        we;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic          flush;
  logic [NF-1:0] valid;
  logic [NF-1:0] ready;
  logic [4:0]    rob  [NF];
  logic [5:0]    phy  [NF];
  logic [4:0]    arch [NF];
  logic [31:0]   data [NF];
  logic          we   [NF];
  logic [NP-1:0] cValid;
  logic [4:0]    cRob  [NP];
  logic [5:0]    cPhy  [NP];
  logic [4:0]    cArch [NP];
  logic [31:0]   cData [NP];
  logic          cWe   [NP];
  logic [2:0]    cSrc  [NP];

  cdb_arbiter #(.NUM_FU(NF), .NUM_PORTS(NP), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rstN), .backend_flush_i(flush),
    .fu_valid_i(valid), .fu_ready_o(ready),
    .fu_rob_id_i(rob), .fu_rd_phy_i(phy), .fu_rd_arch_i(arch),
    .fu_rd_data_i(data), .fu_regf_we_i(we),
    .cdb_valid_o(cValid), .cdb_rob_id_o(cRob), .cdb_rd_phy_o(cPhy),
    .cdb_rd_arch_o(cArch), .cdb_rd_data_o(cData), .cdb_regf_we_o(cWe),
    .cdb_src_o(cSrc)
  );

  ent_t          sbQ [NF][$];
  int            age [NF];
  int            rr;
  int            checks = 0;
  int            errors = 0;
  logic [NP-1:0] expValid;
  int            expSrc [NP];
  logic [NF-1:0] expReady;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randPayload();
    for (int i = 0; i < NF; i++) begin
      rob[i]  = 5'($urandom);
      phy[i]  = 6'($urandom);
      arch[i] = 5'($urandom);
      data[i] = $urandom;
      we[i]   = 1'($urandom);
    end
  endtask

  // Apply inputs for this cycle and compare all outputs against the queues.
  task automatic applyStimulus(input logic r, input logic f, input logic [NF-1:0] v);
    int   p;
    int   idx;
    ent_t got;
    rstN = r; flush = f; valid = v;
    #1;
    for (int i = 0; i < NF; i++) expReady[i] = r && !f && (sbQ[i].size() < 2);
    chk("fu_ready", 64'(ready), 64'(expReady));
    expValid = '0;
    p = 0;
    for (int q = 0; q < NP; q++) expSrc[q] = 0;
    if (r && !f) begin
      for (int k = 0; k < NF; k++) begin
        idx = (rr + k) % NF;
        if (sbQ[idx].size() > 0) age[idx]++;
        if (sbQ[idx].size() > 0 && p < NP) begin
          expValid[p] = 1'b1;
          expSrc[p]   = idx;
          p++;
        end
      end
    end
    chk("cdb_valid", 64'(cValid), 64'(expValid));
    for (int q = 0; q < NP; q++) begin
      chk("cdb_src", 64'(cSrc[q]), 64'(expSrc[q]));
      if (expValid[q]) begin
        got = {cRob[q], cPhy[q], cArch[q], cData[q], cWe[q]};
        chk("cdb_payload", 64'(got), 64'(sbQ[expSrc[q]][0]));
        chk("head_wait", 64'(age[expSrc[q]] <= 2), 64'd1);
      end
    end
  endtask

  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (!rstN || flush) begin
      for (int i = 0; i < NF; i++) begin
        sbQ[i].delete();
        age[i] = 0;
      end
      rr = 0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (expValid[q]) begin
          void'(sbQ[expSrc[q]].pop_front());
          age[expSrc[q]] = 0;
          rr = (expSrc[q] + 1) % NF;
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (valid[i] && expReady[i]) begin
          e = {rob[i], phy[i], arch[i], data[i], we[i]};
          sbQ[i].push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic f, input logic [NF-1:0] v);
    applyStimulus(r, f, v);
    advance();
  endtask

  initial begin
    rr = 0;
    for (int i = 0; i < NF; i++) age[i] = 0;
    rstN = 1'b0; flush = 1'b0; valid = '0;
    randPayload();
    @(negedge clk);

    // Reset holds everything quiet even with requests pending.
    applyStimulus(1'b0, 1'b0, 6'h3F);
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_valid", 64'(cValid), 64'h0);
    advance();
    step(1'b0, 1'b0, 6'h00);
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("release_ready", 64'(ready), 64'h3F);
    advance();

    // Single push on FU2, broadcast one cycle later on port 0.
    rob[2] = 5'd5; data[2] = 32'hDEADBEEF;
    step(1'b1, 1'b0, 6'b000100);
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("single_valid", 64'(cValid), 64'b0001);
    chk("single_src", 64'(cSrc[0]), 64'd2);
    chk("single_rob", 64'(cRob[0]), 64'd5);
    chk("single_data", 64'(cData[0]), 64'hDEADBEEF);
    advance();

    // Flush resets rr, then all six FUs push together.
    step(1'b1, 1'b1, 6'h00);
    randPayload();
    step(1'b1, 1'b0, 6'h3F);
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("all6_c1_valid", 64'(cValid), 64'b1111);
    for (int q = 0; q < NP; q++) chk("all6_c1_src", 64'(cSrc[q]), 64'(q));
    advance();
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("all6_c2_valid", 64'(cValid), 64'b0011);
    chk("all6_c2_src0", 64'(cSrc[0]), 64'd4);
    chk("all6_c2_src1", 64'(cSrc[1]), 64'd5);
    advance();

    // FU1 streams three entries; the pop each cycle keeps it ready.
    for (int n = 0; n < 3; n++) begin
      randPayload();
      applyStimulus(1'b1, 1'b0, 6'b000010);
      chk("stream_ready1", 64'(ready[1]), 64'd1);
      advance();
    end
    step(1'b1, 1'b0, 6'h00);

    // rr is now 2: FU0 waits behind FU2..5 while it pushes a second entry.
    randPayload();
    step(1'b1, 1'b0, 6'h3F);
    randPayload();
    step(1'b1, 1'b0, 6'b000001);
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("full_ready", 64'(ready), 64'b111110);
    applyStimulus(1'b1, 1'b1, 6'h3F);
    chk("flush_valid", 64'(cValid), 64'h0);
    chk("flush_ready", 64'(ready), 64'h0);
    advance();
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("post_flush_ready", 64'(ready), 64'h3F);
    chk("post_flush_valid", 64'(cValid), 64'h0);
    advance();

    // Mid-operation reset with five entries buffered.
    randPayload();
    step(1'b1, 1'b0, 6'h1F);
    applyStimulus(1'b0, 1'b0, 6'h00);
    chk("midreset_valid", 64'(cValid), 64'h0);
    chk("midreset_ready", 64'(ready), 64'h0);
    advance();
    applyStimulus(1'b1, 1'b0, 6'h00);
    chk("midreset_release_ready", 64'(ready), 64'h3F);
    chk("midreset_release_valid", 64'(cValid), 64'h0);
    advance();

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      randPayload();
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0), NF'($urandom));
    end
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 6'h00);
    for (int i = 0; i < NF; i++) chk("drained", 64'(sbQ[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
